// File: rtl/miriscv_timer.sv
// Memory-mapped timer: prescaled 32-bit counter, compare match, W1C status and level IRQ.
// Reads are combinational with zero wait states, and writes take effect on the access edge.
module miriscv_timer #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        irq_o
);

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_PRESC  = 3'd1;
   localparam logic [2:0] REG_COUNT  = 3'd2;
   localparam logic [2:0] REG_CMP    = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   logic               en;
   logic               reload;
   logic               ie;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] div;
   logic [31:0]        count;
   logic [31:0]        cmp;
   logic               match;

   logic [2:0]         idx;
   logic               wr;
   logic               tick;
   logic               hit;
   logic               w1c;
   logic               div_clr;
   logic [31:0]        presc_ext;
   logic               unused_addr;

   assign idx         = data_addr_i[4:2];
   assign unused_addr = ^{data_addr_i[31:5], data_addr_i[1:0]};
   assign wr          = data_req_i & data_we_i;
   assign tick        = en & (div == presc);
   assign hit         = (count == cmp);
   assign w1c         = wr & (idx == REG_STATUS) & data_be_i[0] & data_wdata_i[0];
   assign div_clr     = wr & ((idx == REG_CTRL) | (idx == REG_PRESC));
   assign presc_ext   = 32'(presc);
   assign irq_o       = match & ie;

   function automatic logic [31:0] merge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en     <= 1'b0;
         reload <= 1'b0;
         ie     <= 1'b0;
         presc  <= '0;
         div    <= '0;
         count  <= '0;
         cmp    <= '0;
         match  <= 1'b0;
      end else begin
         if (wr && idx == REG_CTRL && data_be_i[0]) begin
            en     <= data_wdata_i[0];
            reload <= data_wdata_i[1];
            ie     <= data_wdata_i[2];
         end
         if (wr && idx == REG_PRESC)
            presc <= PRESC_W'(merge(presc_ext, data_wdata_i, data_be_i));
         if (wr && idx == REG_CMP)
            cmp <= merge(cmp, data_wdata_i, data_be_i);

         if (div_clr || !en || tick) div <= '0;
         else                        div <= div + PRESC_W'(1);

         // A software write wins over the tick update; the match test still sees the old COUNT.
         if (wr && idx == REG_COUNT) count <= merge(count, data_wdata_i, data_be_i);
         else if (tick)              count <= (hit && reload) ? 32'd0 : count + 32'd1;

         if (tick && hit) match <= 1'b1;
         else if (w1c)    match <= 1'b0;
      end
   end

   always_comb begin
      data_rdata_o = 32'h0;
      if (data_req_i && !data_we_i) begin
         case (idx)
            REG_CTRL:   data_rdata_o = {29'h0, ie, reload, en};
            REG_PRESC:  data_rdata_o = presc_ext;
            REG_COUNT:  data_rdata_o = count;
            REG_CMP:    data_rdata_o = cmp;
            REG_STATUS: data_rdata_o = {31'h0, match};
            default:    data_rdata_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_timer.sv
// Bench for miriscv_timer: register vector table, directed corner sequences, random traffic vs a reference model.
module tb_miriscv_timer;

   localparam int PW = 16;
   localparam logic [31:0] PMASK = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic        m_en, m_reload, m_ie, m_match;
   logic [31:0] m_presc, m_count, m_cmp, m_elapsed;

   always #5 clk = ~clk;

   miriscv_timer #(.PRESC_W(PW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .data_req_i   (req),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_addr_i  (addr),
      .data_wdata_i (wdata),
      .data_rdata_o (rdata),
      .irq_o        (irq)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = w[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_en = 0; m_reload = 0; m_ie = 0; m_match = 0;
      m_presc = 0; m_count = 0; m_cmp = 0; m_elapsed = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[4:2])
         3'd0:    return {29'h0, m_ie, m_reload, m_en};
         3'd1:    return m_presc;
         3'd2:    return m_count;
         3'd3:    return m_cmp;
         3'd4:    return {31'h0, m_match};
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge: the model is advanced from the inputs present before the edge.
   task automatic step();
      logic        tick, hit, w;
      logic [2:0]  r;
      logic        n_en, n_reload, n_ie, n_match;
      logic [31:0] n_presc, n_count, n_cmp, n_elapsed, c;
      w    = req && we;
      r    = addr[4:2];
      tick = m_en && (m_elapsed == m_presc);
      hit  = (m_count == m_cmp);
      n_en = m_en; n_reload = m_reload; n_ie = m_ie;
      n_presc = m_presc; n_cmp = m_cmp; n_count = m_count; n_match = m_match;
      if (w && r == 3'd0) begin
         c = bmerge({29'h0, m_ie, m_reload, m_en}, wdata, be);
         n_en = c[0]; n_reload = c[1]; n_ie = c[2];
      end
      if (w && r == 3'd1) n_presc = bmerge(m_presc, wdata, be) & PMASK;
      if (w && r == 3'd3) n_cmp = bmerge(m_cmp, wdata, be);
      if (w && r == 3'd2)      n_count = bmerge(m_count, wdata, be);
      else if (tick)           n_count = (hit && m_reload) ? 32'd0 : m_count + 32'd1;
      if (tick && hit) n_match = 1'b1;
      else if (w && r == 3'd4 && be[0] && wdata[0]) n_match = 1'b0;
      if ((w && (r == 3'd0 || r == 3'd1)) || !m_en || tick) n_elapsed = 0;
      else n_elapsed = m_elapsed + 1;
      @(posedge clk);
      #1;
      m_en = n_en; m_reload = n_reload; m_ie = n_ie; m_presc = n_presc;
      m_cmp = n_cmp; m_count = n_count; m_match = n_match; m_elapsed = n_elapsed;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
      req = 1; we = 1; addr = a; wdata = d; be = b;
      step();
      req = 0; we = 0; be = 4'h0;
   endtask

   task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
      req = 1; we = 0; addr = a;
      #1;
      check(nm, rdata, exp);
      req = 0;
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];
   logic [31:0] cnt_seq[5];
   logic        irq_seq[5];

   initial begin
      req = 0; we = 0; be = 0; addr = 0; wdata = 0;
      rst_n = 0;
      model_reset();
      #12;
      check("irq_in_reset", {31'h0, irq}, 32'h0);
      peek(32'h08, 32'h0, "count_in_reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) peek(32'(i * 4), 32'h0, $sformatf("reset_reg%0d", i));
      step();

      vecs[0]  = '{1'b1, 32'h00, 32'h0000_0000, 4'hF, 32'h0};
      vecs[1]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0};
      vecs[2]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0};
      vecs[3]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0000_FFFF};
      vecs[4]  = '{1'b1, 32'h0C, 32'h0000_0000, 4'hF, 32'h0};
      vecs[5]  = '{1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0};
      vecs[6]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h00BB_00DD};
      vecs[7]  = '{1'b0, 32'h18, 32'h0,         4'h0, 32'h0};
      vecs[8]  = '{1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0};
      vecs[9]  = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h0};
      vecs[10] = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h00BB_00DD};
      vecs[11] = '{1'b1, 32'h00, 32'hFFFF_FFFE, 4'b0001, 32'h0};
      vecs[12] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h6};
      vecs[13] = '{1'b1, 32'h08, 32'h1234_5678, 4'b1100, 32'h0};
      vecs[14] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h1234_0000};
      vecs[15] = '{1'b0, 32'hFFFF_FF08, 32'h0,  4'h0, 32'h1234_0000};
      vecs[16] = '{1'b1, 32'h00, 32'h0,         4'hF, 32'h0};
      vecs[17] = '{1'b1, 32'h04, 32'h0,         4'hF, 32'h0};
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d, vecs[i].b);
         else begin
            peek(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
            step();
         end
      end

      req = 0; we = 0; addr = 32'h0C;
      #1;
      check("rdata_no_req", rdata, 32'h0);
      step();

      // periodic match with reload and IRQ
      wr(32'h04, 0); wr(32'h0C, 3); wr(32'h08, 0); wr(32'h10, 1); wr(32'h00, 7);
      cnt_seq = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
      irq_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
         step();
         peek(32'h08, cnt_seq[k], $sformatf("periodic_count%0d", k));
         check($sformatf("periodic_irq%0d", k), {31'h0, irq}, {31'h0, irq_seq[k]});
      end
      wr(32'h10, 1);
      check("w1c_irq_drop", {31'h0, irq}, 32'h0);
      peek(32'h10, 32'h0, "w1c_status");
      step(); step();
      check("irq_rematch", {31'h0, irq}, 32'h1);
      wr(32'h00, 3);
      check("ie_clear_irq", {31'h0, irq}, 32'h0);
      peek(32'h10, 32'h1, "ie_clear_match_kept");

      // prescaler and 32-bit wrap
      wr(32'h00, 0); wr(32'h10, 1); wr(32'h04, 4); wr(32'h08, 32'hFFFF_FFFE);
      wr(32'h0C, 5); wr(32'h00, 1);
      for (int k = 1; k <= 15; k++) begin
         step();
         peek(32'h08, 32'hFFFF_FFFE + 32'(k / 5), $sformatf("wrap_count%0d", k));
         peek(32'h10, 32'h0, $sformatf("wrap_status%0d", k));
      end

      // collisions on tick cycles
      wr(32'h00, 0); wr(32'h0C, 32'h102); wr(32'h04, 0); wr(32'h00, 1);
      wr(32'h08, 32'h100);
      peek(32'h08, 32'h100, "count_write_wins");
      step(); step();
      wr(32'h10, 1);
      peek(32'h10, 32'h1, "set_beats_clear");
      peek(32'h08, 32'h103, "count_after_match");
      wr(32'h10, 1);
      wr(32'h0C, 32'h105);
      wr(32'h08, 32'h7);
      peek(32'h08, 32'h7, "count_write_on_match");
      peek(32'h10, 32'h1, "prewrite_match_used");
      wr(32'h10, 32'h1, 4'b1110);
      peek(32'h10, 32'h1, "w1c_needs_be0");
      wr(32'h10, 32'hFFFF_FFFE);
      peek(32'h10, 32'h1, "w1c_needs_bit0");
      wr(32'h10, 32'h1);
      peek(32'h10, 32'h0, "w1c_clears");

      // asynchronous reset while running with IRQ high
      wr(32'h00, 0); wr(32'h10, 1); wr(32'h04, 0); wr(32'h0C, 0); wr(32'h08, 0);
      wr(32'h00, 5); wr(32'h04, 32'hFFFF); wr(32'h08, 32'h55);
      check("pre_reset_irq", {31'h0, irq}, 32'h1);
      peek(32'h08, 32'h55, "pre_reset_count");
      #1;
      rst_n = 0;
      model_reset();
      #1;
      check("async_reset_irq", {31'h0, irq}, 32'h0);
      for (int i = 0; i < 5; i++) peek(32'(i * 4), 32'h0, $sformatf("async_reset_reg%0d", i));
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 10; k++) begin
         peek(32'h08, 32'h0, $sformatf("idle_after_reset%0d", k));
         step();
      end
      peek(32'h00, 32'h0, "ctrl_idle_after_reset");

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [2:0]  ri;
         logic [31:0] a, d;
         r  = $urandom_range(0, 9);
         ri = 3'($urandom_range(0, 7));
         a  = $urandom();
         a[4:2] = ri;
         if (r < 3) begin
            case (ri)
               3'd1:    d = $urandom_range(0, 3);
               3'd2:    d = $urandom_range(0, 12);
               3'd3:    d = $urandom_range(0, 10);
               default: d = $urandom();
            endcase
            req = 1; we = 1; addr = a; wdata = d;
            be = (r == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            step();
            req = 0; we = 0; be = 0;
         end else begin
            if (r > 6) a[4:2] = 3'd2;
            peek(a, model_read(a), $sformatf("rand_read%0d", n));
            step();
         end
         check($sformatf("rand_irq%0d", n), {31'h0, irq}, {31'h0, m_match & m_ie});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miriscv_timer.md
MIRISCV_TIMER -- requirements
Module: miriscv_timer

Interface
REQ-001 Parameter PRESC_W, default 16: prescaler register and divider width in bits, legal range 1..32.
REQ-002 clk_i  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 data_req_i  input  1  bus access strobe; the block is selected by upstream address decode.
REQ-005 data_we_i  input  1  1 = write access, 0 = read access.
REQ-006 data_be_i  input  4  byte enables for writes; bit n qualifies wdata[8n+7:8n].
REQ-007 data_addr_i  input  32  byte address; only bits [4:2] are decoded, all other bits are ignored.
REQ-008 data_wdata_i  input  32  write data.
REQ-009 data_rdata_o  output  32  read data.
REQ-010 irq_o  output  1  level interrupt request, one line of the interrupt controller's int_req bus.

Function
REQ-011 The register map, by offset, SHALL be:
- 0x00 CTRL: bit0 EN, bit1 RELOAD, bit2 IE; bits [31:3] read 0.
- 0x04 PRESC: bits [PRESC_W-1:0].
- 0x08 COUNT: 32 bits.
- 0x0C CMP: 32 bits.
- 0x10 STATUS: bit0 MATCH, write-1-to-clear.
REQ-012 Offsets 0x14..0x1C SHALL read 0, and writes to them SHALL be ignored.
REQ-013 Reads SHALL be combinational, with zero wait states: data_rdata_o = addressed register when data_req_i=1 and data_we_i=0, else 32'h0.
REQ-014 A write SHALL take effect on the clock edge at which data_req_i=1 and data_we_i=1, updating only bytes whose data_be_i bit is set; unimplemented bits SHALL be ignored.
REQ-015 The STATUS write SHALL clear MATCH only when data_be_i[0]=1 and data_wdata_i[0]=1.
REQ-016 Divider: while EN=1, div increments each cycle.
- When div==PRESC, div SHALL return to 0 and a one-cycle internal tick SHALL be asserted.
- PRESC=0 SHALL therefore tick every cycle.
REQ-017 While EN=0, div SHALL hold at 0 and COUNT SHALL hold its value.
REQ-018 On a tick with COUNT==CMP:
- MATCH SHALL set to 1.
- COUNT SHALL load 0 if RELOAD=1, else COUNT+1.
REQ-019 On a tick with COUNT!=CMP, COUNT SHALL load COUNT+1, modulo 2^32 (0xFFFFFFFF wraps to 0, with no MATCH unless CMP matches).
REQ-020 Any write to PRESC or CTRL SHALL reset div to 0 on the same edge.
REQ-021 A software write to COUNT in the same cycle as a tick SHALL take precedence over the increment or reload.
- The match check on that edge SHALL still use the pre-write COUNT.
REQ-022 A MATCH set and a W1C clear in the same cycle SHALL leave MATCH=1 (set wins).
REQ-023 irq_o SHALL equal MATCH & IE, driven from flops with no added latency.
- Clearing IE SHALL drop irq_o without clearing MATCH.
REQ-024 The latency from the EN write edge to the first COUNT increment SHALL be PRESC+1 cycles.

Reset
REQ-025 While rst_n_i=0, all registers SHALL clear immediately, independent of clk_i: CTRL=0, PRESC=0, COUNT=0, CMP=0, MATCH=0, div=0.
REQ-026 Outputs SHALL be irq_o=0 during reset, and data_rdata_o SHALL follow REQ-013 using the reset register values.
REQ-027 Reset asserted mid-count or with irq_o high SHALL abort all activity.
- After release, the block SHALL stay idle until software sets EN.

Verification
REQ-028 Basic periodic match:
- Stimulus: PRESC=0, CMP=3, CTRL=0x7 (EN, RELOAD, IE).
- Response: COUNT sequence 1,2,3,0,1,...; irq_o rises on the edge where 3 reloads to 0.
- Then: a STATUS write of 0x1 drops irq_o one edge later.
REQ-029 Prescaler and wrap:
- Stimulus: PRESC=4, COUNT=0xFFFFFFFE, CMP=5, CTRL=0x1.
- Response: COUNT changes every 5 cycles, 0xFFFFFFFE -> 0xFFFFFFFF -> 0x0 -> 0x1, with MATCH staying 0.
REQ-030 Collisions on a tick cycle:
- Stimulus: write COUNT=0x100 on a tick cycle.
- Response: COUNT reads 0x100 next cycle.
- Stimulus: a W1C on STATUS in the cycle MATCH sets.
- Response: MATCH reads 1.
REQ-031 Byte enables and unmapped offsets:
- Stimulus: write CMP=0xAABBCCDD with be=4'b0101 over CMP=0.
- Response: CMP reads 0x00BB00DD.
- Stimulus: read offset 0x18.
- Response: reads 0.
- Stimulus: data_req_i=0.
- Response: data_rdata_o=0.
REQ-032 Asynchronous reset while running:
- Stimulus: assert rst_n_i low between clock edges while irq_o=1 and COUNT=0x55.
- Response: irq_o and all registers read 0 immediately.
- After release: COUNT stays 0 for 10 cycles.
